// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between NUM_REQ producers. It also
// issues consumer reads, tracks occupancy, flags underflow and drains the FIFO on flush.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 7,
    parameter int CNT_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rd_req,
    input  logic                      flush,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic                      fifo_rd_en,
    input  logic [DATA_W-1:0]         fifo_rd_data,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [CNT_W-1:0]          level,
    output logic                      full,
    output logic                      empty,
    output logic                      flushing,
    output logic                      err_underflow
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0] gnt_idx, cand;
    logic             gnt_found;
    logic             accept;

    assign full     = (level == CNT_W'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign flushing = (state == FLUSH);

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            RUN: begin
                fifo_rd_en = rd_req & ~empty;
                if (flush) state_nxt = FLUSH;
            end
            FLUSH: begin
                fifo_rd_en = ~empty;
                if (empty) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // A full FIFO can still take a word when a read frees a slot in the same cycle.
    assign accept = ~full | fifo_rd_en;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (state == RUN && accept) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (int'(rr_ptr) + k >= NUM_REQ)
                    cand = PTR_W'(int'(rr_ptr) + k - NUM_REQ);
                else
                    cand = PTR_W'(int'(rr_ptr) + k);
                if (!gnt_found && req_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr_data = '0;
        rr_ptr_nxt   = rr_ptr;
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
            fifo_wr_data       = req_data[gnt_idx*DATA_W +: DATA_W];
            rr_ptr_nxt         = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign fifo_wr_en = gnt_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            rr_ptr        <= '0;
            level         <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            err_underflow <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (fifo_wr_en && !fifo_rd_en && !full)
                level <= level + 1'b1;
            else if (fifo_rd_en && !fifo_wr_en && !empty)
                level <= level - 1'b1;
            // Drained words in FLUSH are discarded, never returned to the consumer.
            rd_valid <= fifo_rd_en & (state == RUN);
            if (fifo_rd_en && state == RUN)
                rd_data <= fifo_rd_data;
            if (state == RUN && rd_req && empty)
                err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: emulates the FIFO as a queue and checks every cycle
// against a queue-based reference model under directed and random stimulus.
module tb_fifo_write_arbiter;
    localparam int N     = 4;
    localparam int W     = 32;
    localparam int DEPTH = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_data;
    logic           rd_req, flush, fifo_wr_en, fifo_rd_en, rd_valid;
    logic           full, empty, flushing, err_underflow;
    logic [W-1:0]   fifo_wr_data, fifo_rd_data, rd_data;
    logic [3:0]     level;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] q[$];
    int           m_ptr;
    bit           m_flush, m_err, m_rd_valid;
    logic [W-1:0] m_rd_data;

    logic         obs_rd_en, obs_flushing;
    logic [N-1:0] obs_ready;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rd_req(rd_req), .flush(flush),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
        .full(full), .empty(empty), .flushing(flushing), .err_underflow(err_underflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Asserts rst immediately (wherever in the cycle we are) and checks outputs before any edge.
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rd_req    = 1'b0;
        flush     = 1'b0;
        q.delete();
        m_ptr = 0; m_flush = 0; m_err = 0; m_rd_valid = 0; m_rd_data = '0;
        fifo_rd_data = '0;
        #1;
        check_eq("rst_ready",    64'(req_ready), 64'(0));
        check_eq("rst_wr_en",    64'(fifo_wr_en), 64'(0));
        check_eq("rst_wr_data",  64'(fifo_wr_data), 64'(0));
        check_eq("rst_rd_en",    64'(fifo_rd_en), 64'(0));
        check_eq("rst_rd_valid", 64'(rd_valid), 64'(0));
        check_eq("rst_rd_data",  64'(rd_data), 64'(0));
        check_eq("rst_level",    64'(level), 64'(0));
        check_eq("rst_full",     64'(full), 64'(0));
        check_eq("rst_empty",    64'(empty), 64'(1));
        check_eq("rst_flushing", 64'(flushing), 64'(0));
        check_eq("rst_err",      64'(err_underflow), 64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r,
                        input logic f, output int dut_g);
        int           eg, sz;
        bit           run, exp_rd;
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_wd, popped;
        @(negedge clk);
        req_valid = v; req_data = d; rd_req = r; flush = f;
        #1;
        sz     = q.size();
        run    = !m_flush;
        exp_rd = run ? (r && sz > 0) : (sz > 0);
        eg     = -1;
        if (run && (sz < DEPTH || exp_rd))
            for (int k = 0; k < N; k++)
                if (eg < 0 && v[2'((m_ptr + k) % N)]) eg = (m_ptr + k) % N;
        exp_ready = '0;
        exp_wd    = '0;
        if (eg >= 0) begin
            exp_ready[2'(eg)] = 1'b1;
            exp_wd = W'(d >> (eg * W));
        end
        check_eq("ready",    64'(req_ready), 64'(exp_ready));
        check_eq("wr_en",    64'(fifo_wr_en), 64'(eg >= 0));
        check_eq("wr_data",  64'(fifo_wr_data), 64'(exp_wd));
        check_eq("rd_en",    64'(fifo_rd_en), 64'(exp_rd));
        check_eq("level",    64'(level), 64'(sz));
        check_eq("full",     64'(full), 64'(sz == DEPTH));
        check_eq("empty",    64'(empty), 64'(sz == 0));
        check_eq("flushing", 64'(flushing), 64'(m_flush));
        check_eq("err",      64'(err_underflow), 64'(m_err));
        check_eq("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        if (m_rd_valid) check_eq("rd_data", 64'(rd_data), 64'(m_rd_data));
        obs_rd_en    = fifo_rd_en;
        obs_flushing = flushing;
        obs_ready    = req_ready;
        dut_g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) dut_g = i;
        @(posedge clk);
        #1;
        popped = '0;
        if (exp_rd) popped = q.pop_front();
        if (eg >= 0) q.push_back(exp_wd);
        m_rd_valid = exp_rd && run;
        if (m_rd_valid) m_rd_data = popped;
        if (run && r && sz == 0) m_err = 1;
        if (eg >= 0) m_ptr = (eg + 1) % N;
        if (run) begin
            if (f) m_flush = 1;
        end else if (sz == 0) begin
            m_flush = 0;
        end
        fifo_rd_data = (q.size() > 0) ? q[0] : '0;
    endtask

    initial begin
        int             g, drains, drain_grants, rd_pct;
        logic [N*W-1:0] d;

        do_reset();

        // All four producers requesting: grants rotate 0,1,2,3,0,1,2 until full.
        for (int i = 0; i < DEPTH; i++) begin
            d = {32'hD300_0000 + i, 32'hD200_0000 + i, 32'hD100_0000 + i, 32'hD000_0000 + i};
            step(4'hF, d, 1'b0, 1'b0, g);
            check_eq("t1_grant", 64'(g), 64'(i % N));
        end
        check_eq("t1_level", 64'(level), 64'(7));
        check_eq("t1_full",  64'(full), 64'(1));
        step(4'hF, d, 1'b0, 1'b0, g);
        check_eq("t1_full_ready", 64'(obs_ready), 64'(0));

        // Full FIFO, simultaneous read and write.
        step(4'b0100, d, 1'b1, 1'b0, g);
        check_eq("t2_grant",    64'(g), 64'(2));
        check_eq("t2_level",    64'(level), 64'(7));
        check_eq("t2_rd_valid", 64'(rd_valid), 64'(1));
        check_eq("t2_rd_data",  64'(rd_data), 64'(32'hD000_0000));

        // Single word round trip.
        do_reset();
        step(4'b0100, {32'h0, 32'hA5A5_A5A5, 64'h0}, 1'b0, 1'b0, g);
        check_eq("t3_level1", 64'(level), 64'(1));
        step('0, '0, 1'b1, 1'b0, g);
        check_eq("t3_rd_valid", 64'(rd_valid), 64'(1));
        check_eq("t3_rd_data",  64'(rd_data), 64'(32'hA5A5_A5A5));
        check_eq("t3_level0",   64'(level), 64'(0));
        check_eq("t3_empty",    64'(empty), 64'(1));

        // Underflow is sticky.
        step('0, '0, 1'b1, 1'b0, g);
        check_eq("t4_rd_en", 64'(obs_rd_en), 64'(0));
        check_eq("t4_err",   64'(err_underflow), 64'(1));
        for (int i = 0; i < 5; i++) step(4'b0010, {4{$urandom()}}, 1'(i % 2), 1'b0, g);
        check_eq("t4_err_hold", 64'(err_underflow), 64'(1));

        // Flush with five words queued.
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b0001, {4{32'hF000_0000 + i}}, 1'b0, 1'b0, g);
        check_eq("t5_level5", 64'(level), 64'(5));
        step('0, '0, 1'b0, 1'b1, g);
        drains = 0;
        drain_grants = 0;
        for (int i = 0; i < 20 && flushing; i++) begin
            step(4'($urandom_range(0, 15)), {$urandom(), $urandom(), $urandom(), $urandom()},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g);
            if (obs_flushing && obs_rd_en) drains++;
            if (obs_flushing && obs_ready != '0) drain_grants++;
        end
        check_eq("t5_drains",   64'(drains), 64'(5));
        check_eq("t5_grants",   64'(drain_grants), 64'(0));
        check_eq("t5_flushing", 64'(flushing), 64'(0));
        check_eq("t5_level",    64'(level), 64'(0));

        // Asynchronous reset in the middle of a cycle with data queued.
        do_reset();
        for (int i = 0; i < 3; i++) step(4'hF, {4{32'hC000_0000 + i}}, 1'b0, 1'b0, g);
        check_eq("t6_level3", 64'(level), 64'(3));
        #2;
        do_reset();

        // Random traffic with varying read pressure and occasional flushes.
        for (int i = 0; i < 900; i++) begin
            case ((i / 100) % 3)
                0:       rd_pct = 20;
                1:       rd_pct = 50;
                default: rd_pct = 90;
            endcase
            step(4'($urandom_range(0, 15)), {$urandom(), $urandom(), $urandom(), $urandom()},
                 1'($urandom_range(0, 99) < rd_pct), 1'($urandom_range(0, 49) == 0), g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
